// File: rtl/battlefront_ctrl.sv
// Lane-combat sequencer: divides clk into game ticks, strobes move/damage, routes damage, tracks base hp.
// Latency: move at T, damage at T+2, hp at T+3, fronts 1 cycle; no backpressure, enable only pauses IDLE.
module battlefront_ctrl #(
   parameter int unsigned TICK_DIV = 25_000_000,
   parameter logic [8:0]  LANE_END = 9'd400,
   parameter logic [7:0]  BASE_HP  = 8'd100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       player_alive,
   input  logic       enemy_alive,
   input  logic [8:0] player_pos,
   input  logic [8:0] enemy_pos,
   input  logic [7:0] player_dmg_out,
   input  logic [7:0] enemy_dmg_out,
   output logic       move_scen,
   output logic       damage_scen,
   output logic [8:0] enemy_front,
   output logic [8:0] player_front,
   output logic [7:0] enemy_damage_in,
   output logic [7:0] player_damage_in,
   output logic [7:0] player_base_hp,
   output logic [7:0] enemy_base_hp,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MOVE   = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_DAMAGE = 3'd3;
   localparam logic [2:0] S_OVER   = 3'd4;

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_move;
   logic          r_damage;
   logic [8:0]    r_efront;
   logic [8:0]    r_pfront;
   logic [7:0]    r_edin;
   logic [7:0]    r_pdin;
   logic [7:0]    r_php;
   logic [7:0]    r_ehp;
   logic          r_over;
   logic [1:0]    r_winner;

   // Base attack conditions and damage captured at WAIT exit, applied at DAMAGE exit.
   logic          r_hit_pbase;
   logic          r_hit_ebase;
   logic [7:0]    r_pbase_dmg;
   logic [7:0]    r_ebase_dmg;

   logic          w_tick_end;
   logic          w_both_alive;
   logic [7:0]    w_php_next;
   logic [7:0]    w_ehp_next;

   assign w_tick_end   = (r_cnt == CW'(TICK_DIV - 1));
   assign w_both_alive = player_alive & enemy_alive;

   always_comb begin
      w_php_next = r_php;
      w_ehp_next = r_ehp;
      if (r_hit_pbase) begin
         w_php_next = (r_php > r_pbase_dmg) ? (r_php - r_pbase_dmg) : 8'd0;
      end
      if (r_hit_ebase) begin
         w_ehp_next = (r_ehp > r_ebase_dmg) ? (r_ehp - r_ebase_dmg) : 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_move      <= 1'b0;
         r_damage    <= 1'b0;
         r_efront    <= LANE_END;
         r_pfront    <= 9'd0;
         r_edin      <= 8'd0;
         r_pdin      <= 8'd0;
         r_php       <= BASE_HP;
         r_ehp       <= BASE_HP;
         r_over      <= 1'b0;
         r_winner    <= 2'b00;
         r_hit_pbase <= 1'b0;
         r_hit_ebase <= 1'b0;
         r_pbase_dmg <= 8'd0;
         r_ebase_dmg <= 8'd0;
      end else begin
         r_efront <= player_alive ? player_pos : LANE_END;
         r_pfront <= enemy_alive ? enemy_pos : 9'd0;
         r_move   <= 1'b0;
         r_damage <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  if (w_tick_end) begin
                     r_cnt   <= '0;
                     r_state <= S_MOVE;
                     r_move  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            S_MOVE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_state     <= S_DAMAGE;
               r_damage    <= 1'b1;
               r_edin      <= w_both_alive ? player_dmg_out : 8'd0;
               r_pdin      <= w_both_alive ? enemy_dmg_out : 8'd0;
               r_hit_pbase <= enemy_alive & ~player_alive & (enemy_pos >= LANE_END);
               r_hit_ebase <= player_alive & ~enemy_alive & (player_pos == 9'd0);
               r_pbase_dmg <= enemy_dmg_out;
               r_ebase_dmg <= player_dmg_out;
            end
            S_DAMAGE: begin
               r_edin <= 8'd0;
               r_pdin <= 8'd0;
               r_php  <= w_php_next;
               r_ehp  <= w_ehp_next;
               if ((w_php_next == 8'd0) || (w_ehp_next == 8'd0)) begin
                  r_state  <= S_OVER;
                  r_over   <= 1'b1;
                  r_winner <= {w_php_next == 8'd0, w_ehp_next == 8'd0};
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_OVER: begin
               r_state <= S_OVER;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign move_scen        = r_move;
   assign damage_scen      = r_damage;
   assign enemy_front      = r_efront;
   assign player_front     = r_pfront;
   assign enemy_damage_in  = r_edin;
   assign player_damage_in = r_pdin;
   assign player_base_hp   = r_php;
   assign enemy_base_hp    = r_ehp;
   assign game_over        = r_over;
   assign winner           = r_winner;

endmodule

// File: tb/tb_battlefront_ctrl.sv
// Directed bench for battlefront_ctrl with TICK_DIV=4, LANE_END=16, BASE_HP=10.
module tb_battlefront_ctrl;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       player_alive;
   logic       enemy_alive;
   logic [8:0] player_pos;
   logic [8:0] enemy_pos;
   logic [7:0] player_dmg_out;
   logic [7:0] enemy_dmg_out;

   logic       move_scen, damage_scen, game_over;
   logic [8:0] enemy_front, player_front;
   logic [7:0] enemy_damage_in, player_damage_in, player_base_hp, enemy_base_hp;
   logic [1:0] winner;

   // Second instance starts with empty bases so both hit 0 on its first DAMAGE edge.
   logic       d_move, d_damage, d_over;
   logic [8:0] d_efront, d_pfront;
   logic [7:0] d_edin, d_pdin, d_php, d_ehp;
   logic [1:0] d_winner;

   battlefront_ctrl #(.TICK_DIV(4), .LANE_END(9'd16), .BASE_HP(8'd10)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .player_alive(player_alive), .enemy_alive(enemy_alive),
      .player_pos(player_pos), .enemy_pos(enemy_pos),
      .player_dmg_out(player_dmg_out), .enemy_dmg_out(enemy_dmg_out),
      .move_scen(move_scen), .damage_scen(damage_scen),
      .enemy_front(enemy_front), .player_front(player_front),
      .enemy_damage_in(enemy_damage_in), .player_damage_in(player_damage_in),
      .player_base_hp(player_base_hp), .enemy_base_hp(enemy_base_hp),
      .game_over(game_over), .winner(winner)
   );

   battlefront_ctrl #(.TICK_DIV(4), .LANE_END(9'd16), .BASE_HP(8'd0)) dut_draw (
      .clk(clk), .reset(reset), .enable(enable),
      .player_alive(player_alive), .enemy_alive(enemy_alive),
      .player_pos(player_pos), .enemy_pos(enemy_pos),
      .player_dmg_out(player_dmg_out), .enemy_dmg_out(enemy_dmg_out),
      .move_scen(d_move), .damage_scen(d_damage),
      .enemy_front(d_efront), .player_front(d_pfront),
      .enemy_damage_in(d_edin), .player_damage_in(d_pdin),
      .player_base_hp(d_php), .enemy_base_hp(d_ehp),
      .game_over(d_over), .winner(d_winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, pa, ea;
      logic [8:0] ppos, epos;
      logic [7:0] pdmg, edmg;
      logic       mv, dm;
      logic [8:0] ef, pf;
      logic [7:0] edin, pdin, php, ehp;
      logic       go;
      logic [1:0] win;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   k        = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      k = 0;
   endtask

   task automatic add(input int rst, input int en, input int pa, input int ea,
                      input int ppos, input int epos, input int pdmg, input int edmg,
                      input int mv, input int dm, input int ef, input int pf,
                      input int edin, input int pdin, input int php, input int ehp,
                      input int go, input int win);
      vec_t v;
      v.rst = 1'(rst);   v.en = 1'(en);     v.pa = 1'(pa);     v.ea = 1'(ea);
      v.ppos = 9'(ppos); v.epos = 9'(epos); v.pdmg = 8'(pdmg); v.edmg = 8'(edmg);
      v.mv = 1'(mv);     v.dm = 1'(dm);     v.ef = 9'(ef);     v.pf = 9'(pf);
      v.edin = 8'(edin); v.pdin = 8'(pdin); v.php = 8'(php);   v.ehp = 8'(ehp);
      v.go = 1'(go);     v.win = 2'(win);
      vq.push_back(v);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; player_alive = 1'b0; enemy_alive = 1'b0;
      player_pos = 9'd0; enemy_pos = 9'd0; player_dmg_out = 8'd0; enemy_dmg_out = 8'd0;

      //   rst en pa ea ppos epos pdmg  edmg | mv dm ef pf edin  pdin  php ehp go win
      add(1, 0, 0, 0, 0, 0, 0,    0,      0, 0, 16, 0, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 1, 5, 9, 'h20, 'h40,   0, 0, 5,  9, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 1, 5, 9, 'h20, 'h40,   0, 0, 5,  9, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 1, 5, 9, 'h20, 'h40,   0, 0, 5,  9, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 1, 5, 9, 'h20, 'h40,   1, 0, 5,  9, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 1, 6, 8, 'h20, 'h40,   0, 0, 6,  8, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 1, 6, 8, 'h20, 'h40,   0, 1, 6,  8, 'h20, 'h40, 10, 10, 0, 0);
      add(0, 1, 1, 1, 6, 8, 'h11, 'h22,   0, 0, 6,  8, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 0, 0, 8, 5,    'h22,   0, 0, 0,  0, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 0, 0, 8, 5,    'h22,   0, 0, 0,  0, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 0, 0, 8, 5,    'h22,   0, 0, 0,  0, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 0, 0, 8, 5,    'h22,   1, 0, 0,  0, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 0, 0, 8, 5,    'h22,   0, 0, 0,  0, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 0, 0, 8, 5,    'h22,   0, 1, 0,  0, 0,    0,    10, 10, 0, 0);
      add(0, 1, 1, 0, 7, 8, 99,   'h22,   0, 0, 7,  0, 0,    0,    10, 5,  0, 0);
      add(0, 0, 1, 1, 7, 8, 1,    1,      0, 0, 7,  8, 0,    0,    10, 5,  0, 0);
      add(0, 0, 1, 1, 7, 8, 1,    1,      0, 0, 7,  8, 0,    0,    10, 5,  0, 0);
      add(0, 0, 1, 1, 7, 8, 1,    1,      0, 0, 7,  8, 0,    0,    10, 5,  0, 0);
      add(0, 0, 1, 1, 7, 8, 1,    1,      0, 0, 7,  8, 0,    0,    10, 5,  0, 0);
      add(0, 1, 1, 1, 7, 8, 1,    1,      0, 0, 7,  8, 0,    0,    10, 5,  0, 0);
      add(0, 1, 1, 1, 7, 8, 1,    1,      0, 0, 7,  8, 0,    0,    10, 5,  0, 0);
      add(0, 1, 1, 1, 7, 8, 1,    1,      0, 0, 7,  8, 0,    0,    10, 5,  0, 0);
      add(0, 1, 1, 1, 7, 8, 1,    1,      1, 0, 7,  8, 0,    0,    10, 5,  0, 0);

      @(posedge clk);
      #1;
      foreach (vq[i]) begin
         reset = vq[i].rst; enable = vq[i].en;
         player_alive = vq[i].pa; enemy_alive = vq[i].ea;
         player_pos = vq[i].ppos; enemy_pos = vq[i].epos;
         player_dmg_out = vq[i].pdmg; enemy_dmg_out = vq[i].edmg;
         tick();
         chk($sformatf("v%0d.move", i),  int'(move_scen),        int'(vq[i].mv));
         chk($sformatf("v%0d.dmg", i),   int'(damage_scen),      int'(vq[i].dm));
         chk($sformatf("v%0d.efront", i), int'(enemy_front),     int'(vq[i].ef));
         chk($sformatf("v%0d.pfront", i), int'(player_front),    int'(vq[i].pf));
         chk($sformatf("v%0d.edin", i),  int'(enemy_damage_in),  int'(vq[i].edin));
         chk($sformatf("v%0d.pdin", i),  int'(player_damage_in), int'(vq[i].pdin));
         chk($sformatf("v%0d.php", i),   int'(player_base_hp),   int'(vq[i].php));
         chk($sformatf("v%0d.ehp", i),   int'(enemy_base_hp),    int'(vq[i].ehp));
         chk($sformatf("v%0d.over", i),  int'(game_over),        int'(vq[i].go));
         chk($sformatf("v%0d.winner", i), int'(winner),          int'(vq[i].win));
      end

      // Both dead: 7-cycle tick period, damage 2 cycles after move, no damage routed.
      enable = 1'b1; player_alive = 1'b0; enemy_alive = 1'b0;
      player_dmg_out = 8'h33; enemy_dmg_out = 8'h44;
      do_reset();
      for (int c = 0; c < 21; c++) begin
         tick();
         chk($sformatf("dead.move@%0d", k), int'(move_scen),   int'(k % 7 == 4));
         chk($sformatf("dead.dmg@%0d", k),  int'(damage_scen), int'(k % 7 == 6));
         chk($sformatf("dead.edin@%0d", k), int'(enemy_damage_in),  0);
         chk($sformatf("dead.pdin@%0d", k), int'(player_damage_in), 0);
      end

      // Player dead, enemy at player base: 10,7,4,1,0 then game over, enemy wins.
      player_alive = 1'b0; enemy_alive = 1'b1; enemy_pos = 9'd16; enemy_dmg_out = 8'd3;
      player_dmg_out = 8'd9;
      do_reset();
      for (int c = 0; c < 42; c++) begin
         int n;
         int hp;
         tick();
         n  = (k / 7 > 4) ? 4 : k / 7;
         hp = 10 - 3 * n;
         if (hp < 0) hp = 0;
         chk($sformatf("base.move@%0d", k), int'(move_scen),   int'(k % 7 == 4 && k < 28));
         chk($sformatf("base.dmg@%0d", k),  int'(damage_scen), int'(k % 7 == 6 && k < 28));
         chk($sformatf("base.php@%0d", k),  int'(player_base_hp), hp);
         chk($sformatf("base.ehp@%0d", k),  int'(enemy_base_hp), 10);
         chk($sformatf("base.over@%0d", k), int'(game_over), int'(k >= 28));
         chk($sformatf("base.win@%0d", k),  int'(winner), (k >= 28) ? 2 : 0);
         chk($sformatf("base.efront@%0d", k), int'(enemy_front), 16);
         chk($sformatf("draw.over@%0d", k), int'(d_over),   int'(k >= 7));
         chk($sformatf("draw.win@%0d", k),  int'(d_winner), (k >= 7) ? 3 : 0);
      end

      // Enable dropped during MOVE: sequence finishes, counter frozen until re-enabled.
      player_alive = 1'b0; enemy_alive = 1'b0;
      do_reset();
      for (int c = 0; c < 4; c++) tick();
      chk("pause.move", int'(move_scen), 1);
      enable = 1'b0;
      tick();
      chk("pause.wait_dmg", int'(damage_scen), 0);
      tick();
      chk("pause.dmg", int'(damage_scen), 1);
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("pause.nomove@%0d", k), int'(move_scen), 0);
         chk($sformatf("pause.nodmg@%0d", k),  int'(damage_scen), 0);
      end
      enable = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("resume.move@%0d", k), int'(move_scen), int'(k == 30));
      end

      // Reset during WAIT aborts the pending damage strobe.
      player_alive = 1'b1; enemy_alive = 1'b1; player_pos = 9'd5; enemy_pos = 9'd9;
      player_dmg_out = 8'h20; enemy_dmg_out = 8'h40;
      do_reset();
      for (int c = 0; c < 5; c++) tick();
      reset = 1'b1; player_alive = 1'b0;
      tick();
      chk("rst.move", int'(move_scen), 0);
      chk("rst.dmg",  int'(damage_scen), 0);
      chk("rst.edin", int'(enemy_damage_in), 0);
      chk("rst.pdin", int'(player_damage_in), 0);
      chk("rst.efront", int'(enemy_front), 16);
      chk("rst.pfront", int'(player_front), 0);
      chk("rst.php", int'(player_base_hp), 10);
      chk("rst.ehp", int'(enemy_base_hp), 10);
      chk("rst.over", int'(game_over), 0);
      chk("rst.win", int'(winner), 0);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("rst.nodmg%0d", c), int'(damage_scen), 0);
         chk($sformatf("rst.efront%0d", c), int'(enemy_front), 16);
      end
      chk("rst.pfront_live", int'(player_front), 9);
      player_alive = 1'b1;
      tick();
      chk("front.alive", int'(enemy_front), 5);
      player_alive = 1'b0;
      tick();
      chk("front.dead", int'(enemy_front), 16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
